// File: rtl/pe_dispatch.sv
// pe_dispatch: feeds one PE with command-framed operand pairs and
// collects its results in a credit-protected show-ahead FIFO.
package pe_pkg;

   typedef logic [11:0] coeff_t;

   typedef enum logic [1:0] {
      PE_MODE_NTT    = 2'd0,
      PE_MODE_ADDSUB = 2'd1,
      PE_MODE_CWM    = 2'd2,
      PE_MODE_COMP   = 2'd3
   } pe_mode_e;

endpackage

module pe_dispatch
   import pe_pkg::*;
#(
   parameter int RES_DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     cmd_valid_i,
   output logic     cmd_ready_o,
   input  pe_mode_e cmd_mode_i,
   input  logic [8:0] cmd_len_i,
   input  logic     op_valid_i,
   output logic     op_ready_o,
   input  coeff_t   op_a_i,
   input  coeff_t   op_b_i,
   input  coeff_t   op_w_i,
   output coeff_t   pe_a_o,
   output coeff_t   pe_b_o,
   output coeff_t   pe_w_o,
   output pe_mode_e pe_ctrl_o,
   output logic     pe_valid_o,
   input  coeff_t   pe_u_i,
   input  coeff_t   pe_v_i,
   input  logic     pe_valid_i,
   output logic     res_valid_o,
   input  logic     res_ready_i,
   output coeff_t   res_u_o,
   output coeff_t   res_v_o,
   output logic     busy_o,
   output logic     done_o,
   output logic     err_o
);

   localparam int PW = $clog2(RES_DEPTH);
   localparam int CW = $clog2(RES_DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(RES_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_L = (CW + 1)'(RES_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e state;
   state_e state_nx;

   logic [8:0]    len;
   logic [8:0]    issued;
   logic [CW-1:0] inflight;
   logic [CW-1:0] count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW:0]   used;

   coeff_t mem_u [0:RES_DEPTH-1];
   coeff_t mem_v [0:RES_DEPTH-1];

   logic accept;
   logic credit_ok;
   logic issue;
   logic issue_last;
   logic push;
   logic pop;
   logic drain_ok;

   assign accept     = (state == IDLE) && cmd_valid_i;
   assign used       = {1'b0, count} + {1'b0, inflight};
   assign credit_ok  = used < DEPTH_L;
   assign issue      = op_valid_i && op_ready_o;
   assign issue_last = issue && (issued == (len - 9'd1));
   assign push       = pe_valid_i && (inflight != '0);
   assign pop        = res_valid_o && res_ready_i;
   assign drain_ok   = (inflight == '0) && (count == '0);

   assign pe_valid_o = issue;
   assign pe_a_o     = op_a_i;
   assign pe_b_o     = op_b_i;
   assign pe_w_o     = op_w_i;

   assign res_valid_o = count != '0;
   assign res_u_o     = mem_u[rd_ptr];
   assign res_v_o     = mem_v[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (cmd_valid_i && (cmd_len_i != 9'd0))
               state_nx = ISSUE;
         end
         ISSUE: begin
            if (issue_last) state_nx = DRAIN;
         end
         DRAIN: begin
            if (drain_ok) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = 1'b0;
      busy_o      = 1'b0;
      op_ready_o  = 1'b0;
      unique case (state)
         IDLE:  cmd_ready_o = 1'b1;
         ISSUE: begin
            busy_o     = 1'b1;
            op_ready_o = (issued < len) && credit_ok;
         end
         DRAIN: busy_o = 1'b1;
         default: ;
      endcase
   end

   // done is registered so it lands in the first cycle back in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         len       <= '0;
         issued    <= '0;
         pe_ctrl_o <= PE_MODE_NTT;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         done_o <= (accept && (cmd_len_i == 9'd0)) ||
                   ((state == DRAIN) && drain_ok);
         if (accept) begin
            len       <= cmd_len_i;
            issued    <= '0;
            pe_ctrl_o <= cmd_mode_i;
         end else if (issue) begin
            issued <= issued + 9'd1;
         end
         if (pe_valid_i && (inflight == '0))
            err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         unique case ({issue, push})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_u[wr_ptr] <= pe_u_i;
         mem_v[wr_ptr] <= pe_v_i;
      end
   end

endmodule

// File: tb/tb_pe_dispatch.sv
// Bench for pe_dispatch: behavioural 3-cycle PE plus a result
// scoreboard, table-driven commands and hand-written corner cases.
module tb_pe_dispatch;
   import pe_pkg::*;

   localparam int DEPTH = 8;
   localparam int Q     = 3329;

   typedef struct {
      coeff_t u;
      coeff_t v;
   } res_t;

   typedef struct {
      pe_mode_e mode;
      int       len;
      int       b;
      int       w;
      int       u0;
      int       v0;
   } vec_t;

   logic     clk = 1'b0;
   logic     rst;
   logic     cmd_valid;
   logic     cmd_ready;
   pe_mode_e cmd_mode;
   logic [8:0] cmd_len;
   logic     op_valid;
   logic     op_ready;
   coeff_t   op_a, op_b, op_w;
   coeff_t   pe_a, pe_b, pe_w;
   pe_mode_e pe_ctrl;
   logic     pe_valid_out;
   coeff_t   pe_u = '0;
   coeff_t   pe_v = '0;
   logic     pe_valid_in = 1'b0;
   logic     res_valid;
   logic     res_ready;
   coeff_t   res_u, res_v;
   logic     busy, done, err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   pe_mode_e cur_mode;
   logic     spur;
   int       stalls;
   int       acc_cyc;
   int       iss_mark;
   int       res_mark;

   int     n_issue = 0;
   int     n_res   = 0;
   int     n_done  = 0;
   int     n_busy  = 0;
   int     n_resv  = 0;
   int     first_iss, last_iss, done_cyc;
   coeff_t first_u, first_v;
   res_t   exp_q[$];

   logic   s0, s1, s2;
   res_t   d0, d1, d2;

   vec_t tbl[5];

   pe_dispatch #(.RES_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_mode_i(cmd_mode), .cmd_len_i(cmd_len),
      .op_valid_i(op_valid), .op_ready_o(op_ready),
      .op_a_i(op_a), .op_b_i(op_b), .op_w_i(op_w),
      .pe_a_o(pe_a), .pe_b_o(pe_b), .pe_w_o(pe_w),
      .pe_ctrl_o(pe_ctrl), .pe_valid_o(pe_valid_out),
      .pe_u_i(pe_u), .pe_v_i(pe_v), .pe_valid_i(pe_valid_in),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_u_o(res_u), .res_v_o(res_v),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t calc(input pe_mode_e m, input int a,
                                 input int b, input int w);
      res_t r;
      int t;
      t = (b * w) % Q;
      case (m)
         PE_MODE_NTT: begin
            r.u = coeff_t'((a + t) % Q);
            r.v = coeff_t'((a - t + Q) % Q);
         end
         PE_MODE_ADDSUB: begin
            r.u = coeff_t'((a + b) % Q);
            r.v = coeff_t'((a - b + Q) % Q);
         end
         PE_MODE_CWM: begin
            r.u = coeff_t'((a * w) % Q);
            r.v = coeff_t'(t);
         end
         default: begin
            r.u = coeff_t'(a);
            r.v = coeff_t'(t);
         end
      endcase
      return r;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // PE model, scoreboard and event recorder, all away from the edge
   always @(negedge clk) begin
      logic f;
      res_t e;
      if (rst) begin
         s0 = 0; s1 = 0; s2 = 0;
         pe_valid_in = 0;
         exp_q.delete();
      end else begin
         pe_valid_in = s2;
         pe_u = d2.u;
         pe_v = d2.v;
         s2 = s1; d2 = d1;
         s1 = s0; d1 = d0;
         s0 = pe_valid_out;
         if (pe_valid_out)
            d0 = calc(pe_ctrl, int'(pe_a), int'(pe_b), int'(pe_w));
         if (spur) begin
            pe_valid_in = 1;
            pe_u = 12'd111;
            pe_v = 12'd222;
         end
         f = op_valid && op_ready;
         check("pe_valid_gate", int'(pe_valid_out), int'(f));
         if (f) begin
            exp_q.push_back(calc(cur_mode, int'(op_a),
                                 int'(op_b), int'(op_w)));
            if (n_issue == iss_mark) first_iss = cyc;
            last_iss = cyc;
            n_issue++;
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("res_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("res_u", int'(res_u), int'(e.u));
               check("res_v", int'(res_v), int'(e.v));
               if (n_res == res_mark) begin
                  first_u = res_u;
                  first_v = res_v;
               end
               n_res++;
            end
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (busy) n_busy++;
         if (res_valid) n_resv++;
      end
   end

   task automatic send(input pe_mode_e m, input int len);
      logic ok;
      cur_mode  = m;
      cmd_mode  = m;
      cmd_len   = len[8:0];
      cmd_valid = 1;
      acc_cyc   = cyc;
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      cmd_valid = 0;
      check("cmd_ready", int'(ok), 1);
   endtask

   task automatic feed(input int n, input int b, input int w);
      int i;
      int g;
      logic f;
      i = 0; g = 0; stalls = 0;
      while (i < n && g < 2000) begin
         op_valid = 1;
         op_a = coeff_t'(i);
         op_b = coeff_t'(b);
         op_w = coeff_t'(w);
         @(negedge clk);
         f = op_ready;
         if (!f) stalls++;
         @(posedge clk); #1;
         if (f) i++;
         g++;
      end
      op_valid = 0;
      if (i < n) check("feed_timeout", i, n);
   endtask

   task automatic wait_done(input int tgt, input int bound);
      int g;
      g = 0;
      while (n_done < tgt && g < bound) begin
         @(posedge clk); #1;
         g++;
      end
      if (n_done < tgt) check("done_timeout", n_done, tgt);
   endtask

   task automatic run_row(input int k, input vec_t r);
      int i0, r0, dn0;
      i0 = n_issue; r0 = n_res; dn0 = n_done;
      iss_mark = n_issue; res_mark = n_res;
      res_ready = 1;
      send(r.mode, r.len);
      feed(r.len, r.b, r.w);
      wait_done(dn0 + 1, 600);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("row%0d_issues", k), n_issue - i0, r.len);
      check($sformatf("row%0d_results", k), n_res - r0, r.len);
      check($sformatf("row%0d_u0", k), int'(first_u), r.u0);
      check($sformatf("row%0d_v0", k), int'(first_v), r.v0);
      check($sformatf("row%0d_stalls", k), stalls, 0);
      check($sformatf("row%0d_span", k), last_iss - first_iss, r.len - 1);
      check($sformatf("row%0d_done_lat", k), done_cyc - last_iss, 6);
      check($sformatf("row%0d_done_cnt", k), n_done - dn0, 1);
      check($sformatf("row%0d_q_empty", k), exp_q.size(), 0);
      check($sformatf("row%0d_err", k), int'(err), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int i0, r0, dn0, b0, g, bad_ctrl;
      logic ok;

      tbl[0] = '{PE_MODE_NTT,    4,   1,  17,   17, 3312};
      tbl[1] = '{PE_MODE_ADDSUB, 256, 5,  0,    5,  3324};
      tbl[2] = '{PE_MODE_CWM,    7,   2,  10,   0,  20};
      tbl[3] = '{PE_MODE_COMP,   3,   3,  7,    0,  21};
      tbl[4] = '{PE_MODE_NTT,    1,   100, 33,  3300, 29};

      rst = 1; cmd_valid = 0; cmd_mode = PE_MODE_NTT; cmd_len = '0;
      op_valid = 0; op_a = '0; op_b = '0; op_w = '0;
      res_ready = 1; spur = 0; cur_mode = PE_MODE_NTT;
      iss_mark = 0; res_mark = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_pe_valid", int'(pe_valid_out), 0);
      check("rst_ctrl", int'(pe_ctrl), int'(PE_MODE_NTT));
      @(posedge clk); #1;

      for (int k = 0; k < 5; k++) run_row(k, tbl[k]);

      // zero-length command with operands on offer
      i0 = n_issue; dn0 = n_done; b0 = n_busy;
      op_valid = 1; op_a = 12'd9; op_b = 12'd9; op_w = 12'd9;
      send(PE_MODE_CWM, 0);
      repeat (5) @(posedge clk);
      #1 op_valid = 0;
      check("len0_done_cnt", n_done - dn0, 1);
      check("len0_done_lat", done_cyc - acc_cyc, 1);
      check("len0_busy", n_busy - b0, 0);
      check("len0_issues", n_issue - i0, 0);

      // credit stall with the result side blocked
      i0 = n_issue; r0 = n_res; dn0 = n_done;
      iss_mark = n_issue; res_mark = n_res;
      res_ready = 0;
      send(PE_MODE_CWM, 20);
      fork
         feed(20, 2, 10);
         begin
            repeat (30) @(posedge clk);
            #1;
            check("credit_issued", n_issue - i0, DEPTH);
            check("credit_ready", int'(op_ready), 0);
            check("credit_nores", n_res - r0, 0);
            res_ready = 1;
         end
      join
      wait_done(dn0 + 1, 400);
      repeat (2) @(posedge clk);
      #1;
      check("credit_results", n_res - r0, 20);
      check("credit_issues", n_issue - i0, 20);
      check("credit_u0", int'(first_u), 0);
      check("credit_v0", int'(first_v), 20);
      check("credit_q_empty", exp_q.size(), 0);
      check("credit_err", int'(err), 0);

      // back-to-back commands: mode register holds until done
      r0 = n_res; dn0 = n_done;
      send(PE_MODE_NTT, 2);
      feed(2, 1, 17);
      cmd_mode = PE_MODE_COMP; cmd_len = 9'd2; cmd_valid = 1;
      ok = 0; g = 0; bad_ctrl = 0;
      while (!ok && g < 50) begin
         @(negedge clk);
         if (pe_ctrl != PE_MODE_NTT) bad_ctrl++;
         if (cmd_ready) begin
            ok = 1;
            check("b2b_done_at_idle", int'(done), 1);
         end
         @(posedge clk); #1;
         g++;
      end
      cmd_valid = 0;
      cur_mode = PE_MODE_COMP;
      check("b2b_accepted", int'(ok), 1);
      check("b2b_ctrl_held", bad_ctrl, 0);
      check("b2b_ctrl_new", int'(pe_ctrl), int'(PE_MODE_COMP));
      feed(2, 3, 7);
      wait_done(dn0 + 2, 200);
      repeat (2) @(posedge clk);
      #1;
      check("b2b_results", n_res - r0, 4);
      check("b2b_q_empty", exp_q.size(), 0);

      // reset in the middle of an issue phase
      send(PE_MODE_CWM, 10);
      feed(3, 4, 5);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      op_valid = 1;
      @(negedge clk);
      check("mid_cmd_ready", int'(cmd_ready), 1);
      check("mid_busy", int'(busy), 0);
      check("mid_op_ready", int'(op_ready), 0);
      check("mid_pe_valid", int'(pe_valid_out), 0);
      check("mid_res_valid", int'(res_valid), 0);
      check("mid_done", int'(done), 0);
      check("mid_err", int'(err), 0);
      check("mid_ctrl", int'(pe_ctrl), int'(PE_MODE_NTT));
      @(posedge clk);
      #1 op_valid = 0;
      repeat (6) @(posedge clk);
      #1;
      check("mid_err_later", int'(err), 0);

      // stray PE return while idle
      b0 = n_resv;
      spur = 1;
      @(posedge clk);
      #1 spur = 0;
      repeat (3) @(posedge clk);
      #1;
      check("spur_err", int'(err), 1);
      check("spur_res_valid", n_resv - b0, 0);
      r0 = n_res; dn0 = n_done;
      send(PE_MODE_NTT, 2);
      feed(2, 1, 17);
      wait_done(dn0 + 1, 200);
      repeat (2) @(posedge clk);
      #1;
      check("spur_after_results", n_res - r0, 2);
      check("spur_sticky", int'(err), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_dispatch.md
PE_DISPATCH -- requirements
Module: pe_dispatch

Interface
REQ-001 SHALL have parameter RES_DEPTH, default 8, result FIFO depth in entries (legal 5..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports cmd_valid_i input 1, cmd_ready_o output 1  command handshake.
REQ-005 SHALL have ports cmd_mode_i input pe_mode_e, cmd_len_i input 9  operation mode and operand-pair count (0..256).
REQ-006 SHALL have ports op_valid_i input 1, op_ready_o output 1  operand-stream handshake.
REQ-007 SHALL have ports op_a_i, op_b_i, op_w_i  input  coeff_t each  operands A, B, W.
REQ-008 SHALL have ports pe_a_o, pe_b_o, pe_w_o output coeff_t each; pe_ctrl_o output pe_mode_e; pe_valid_o output 1  drive to pe0 a0_i/b0_i/w0_i/ctrl_i/valid_i.
REQ-009 SHALL have ports pe_u_i, pe_v_i input coeff_t each; pe_valid_i input 1  from pe0 u0_o/v0_o/valid_o.
REQ-010 SHALL have ports res_valid_o output 1, res_ready_i input 1, res_u_o, res_v_o output coeff_t each  result stream.
REQ-011 SHALL have ports busy_o output 1, done_o output 1 (one-cycle pulse), err_o output 1 (sticky).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, DRAIN; cmd_ready_o = 1 only in IDLE.
REQ-013 IDLE: on cmd_valid_i, SHALL latch mode and len; len 0 -> done_o pulse next cycle, stay IDLE; else -> ISSUE.
REQ-014 pe_ctrl_o SHALL be a register holding the latched mode, unchanged through ISSUE and DRAIN and until the next accepted command.
REQ-015 op_ready_o SHALL be 1 only in ISSUE with issued < len and (fifo_count + inflight) < RES_DEPTH.
REQ-016 pe_valid_o SHALL equal op_valid_i AND op_ready_o (combinational); pe_a_o/pe_b_o/pe_w_o SHALL pass op_a_i/op_b_i/op_w_i directly.
REQ-017 Each issue SHALL increment issued and inflight; each pe_valid_i SHALL decrement inflight; simultaneous issue and return SHALL leave inflight unchanged.
REQ-018 ISSUE -> DRAIN in the cycle after the issue that makes issued == len.
REQ-019 DRAIN -> IDLE when inflight == 0 and FIFO empty; done_o SHALL pulse in the same cycle IDLE is entered.
REQ-020 Result FIFO SHALL store {pe_u_i, pe_v_i} on pe_valid_i; show-ahead; entry visible on res_valid_o the cycle after capture; pop on res_valid_o AND res_ready_i; simultaneous push/pop SHALL keep count.
REQ-021 Credit rule (REQ-015) SHALL guarantee no FIFO overflow regardless of res_ready_i; full throughput (1 pair/cycle) SHALL be sustained when res_ready_i is held 1.
REQ-022 pe_valid_i with inflight == 0 SHALL be dropped and set err_o; err_o clears only on reset.
REQ-023 busy_o SHALL be 1 in ISSUE and DRAIN.
REQ-024 Result order SHALL equal issue order; count of results per command SHALL equal len.

Reset
REQ-025 On rst: state IDLE, issued/inflight/FIFO cleared, pe_ctrl_o = PE_MODE_NTT, done_o/err_o/busy_o/res_valid_o/pe_valid_o = 0, cmd_ready_o = 1 from the first cycle after rst deasserts.
REQ-026 rst mid-operation SHALL abandon the command; pe_valid_i returns from in-flight pairs after reset SHALL set err_o (bench holds pe0 in reset together).

Verification
REQ-027 NTT, len 4, A=i, B=1, W=17, res_ready_i=1 -> 4 issues in 4 consecutive cycles, results U=A+17, V=A-17 mod 3329 in order, done_o one pulse 6 cycles after the last issue.
REQ-028 ADDSUB, len 256, continuous operands -> op_ready_o never drops, 256 results, no err_o.
REQ-029 CWM, len 20, res_ready_i=0 -> exactly RES_DEPTH pairs issued then op_ready_o=0; set res_ready_i=1 -> all 20 results delivered, no loss or duplication.
REQ-030 Back-to-back NTT len 2 then COMP len 2 -> pe_ctrl_o switches only after done_o of the first command; COMP results U=A, V=B*W after 3-cycle PE latency.
REQ-031 cmd_len_i=0 -> done_o pulses once, busy_o stays 0, pe_valid_o never asserted.
REQ-032 Spurious pe_valid_i in IDLE -> err_o=1 and sticky, res_valid_o stays 0; rst during ISSUE with len 10 after 3 issues -> all outputs at REQ-025 values next cycle.
